// File: rtl/updown_counter_n.sv
// ---------------------------------------------------------------------------
// updown_counter_n
//   Parametrised synchronous up/down counter with a count range of
//   0..MODULUS-1. The counter either wraps or saturates at the bounds, clamps
//   parallel-load data into range, and flags a wrap or saturate event on the
//   edge that produced it. An active-low ripple-carry output lets several
//   instances be chained into one wide counter: the rco_ of one stage drives
//   the ct_ of the next stage.
//
// Parameters
//   WIDTH    : counter width in bits (2..16)
//   MODULUS  : number of count states (2..2^WIDTH)
//   SATURATE : 0 = wrap at the bounds, 1 = hold at the bound
//
// Ports
//   cp    in   clock, rising edge
//   cr_   in   asynchronous active-low clear of q and m
//   ld_   in   synchronous active-low parallel load (overrides counting)
//   ct_   in   active-low count enable / cascade input
//   u_    in   direction, 1 = up, 0 = down
//   d     in   parallel load data, clamped to MODULUS-1
//   q     out  registered count value
//   m     out  registered wrap/saturate flag for the last count edge
//   tc    out  combinational terminal count for the current direction
//   rco_  out  combinational active-low ripple carry, low only in cp-low phase
// ---------------------------------------------------------------------------

// Checker holding the run-time properties of the counter.
module updown_counter_n_chk #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic             cp,
    input logic             cr_,
    input logic             ct_,
    input logic             rco_,
    input logic [WIDTH-1:0] q
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    // The count must never leave the legal range 0..MAX.
    a_q_range: assert property (@(posedge cp) disable iff (!cr_) (q <= MAX_C));

    // A disabled stage must never pass a carry on to the next stage.
    always_comb begin
        a_rco_gated: assert (!(ct_ && !rco_));
    end
endmodule

module updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             cp,
    input  logic             cr_,
    input  logic             ld_,
    input  logic             ct_,
    input  logic             u_,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             m,
    output logic             tc,
    output logic             rco_
);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT_C  = (SATURATE != 0);

    // Value taken when counting past a bound: hold in saturate mode,
    // otherwise jump to the opposite bound.
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT_C = SAT_C ? MAX_C : ZERO_C;
    localparam logic [WIDTH-1:0] DN_LIMIT_NEXT_C = SAT_C ? ZERO_C : MAX_C;

    logic [WIDTH-1:0] q_r;
    logic             m_r;
    logic [WIDTH-1:0] q_next_s;
    logic             m_next_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             tc_s;

    // Out-of-range load data is clamped so q can never hold a value above MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > MAX_C) begin
            r = MAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign at_max_s  = (q_r == MAX_C);
    assign at_zero_s = (q_r == ZERO_C);

    // Next-state selection: load beats count, count beats idle.
    always_comb begin
        q_next_s = q_r;
        m_next_s = m_r;
        if (!ld_) begin
            q_next_s = clamp_load(d);
            m_next_s = 1'b0;
        end else if (!ct_) begin
            if (u_) begin
                if (at_max_s) begin
                    q_next_s = UP_LIMIT_NEXT_C;
                    m_next_s = 1'b1;
                end else begin
                    q_next_s = q_r + ONE_C;
                    m_next_s = 1'b0;
                end
            end else begin
                if (at_zero_s) begin
                    q_next_s = DN_LIMIT_NEXT_C;
                    m_next_s = 1'b1;
                end else begin
                    q_next_s = q_r - ONE_C;
                    m_next_s = 1'b0;
                end
            end
        end else begin
            // Idle: m keeps its last value until the next load or count edge.
            q_next_s = q_r;
            m_next_s = m_r;
        end
    end

    // Count and flag registers with asynchronous clear.
    always_ff @(posedge cp or negedge cr_) begin
        if (!cr_) begin
            q_r <= ZERO_C;
            m_r <= 1'b0;
        end else begin
            q_r <= q_next_s;
            m_r <= m_next_s;
        end
    end

    // Terminal count follows u_ combinationally so a direction change is
    // visible to the next stage before the following edge.
    assign tc_s = (u_ & at_max_s) | (~u_ & at_zero_s);

    assign q    = q_r;
    assign m    = m_r;
    assign tc   = tc_s;
    // Carry is confined to the cp-low half so the next stage sees a clean
    // enable that is released as cp rises.
    assign rco_ = ~(tc_s & ~ct_ & ~cp);

    updown_counter_n_chk #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_chk (
        .cp   (cp),
        .cr_  (cr_),
        .ct_  (ct_),
        .rco_ (rco_),
        .q    (q_r)
    );
endmodule

// File: tb/tb_updown_counter_n.sv
// Testbench for updown_counter_n: three single instances (MOD16 wrap,
// MOD10 wrap, MOD10 saturate) share one set of inputs and are tracked by an
// arithmetic reference model; a two-stage MOD10 cascade is checked as a
// decimal 0..99 counter.
module tb_updown_counter_n;

    logic cp = 1'b0;
    always #5 cp = ~cp;

    logic       cr_, ld_, ct_, u_;
    logic [3:0] d;
    wire  [3:0] q_a, q_w, q_s;
    wire        m_a, m_w, m_s, tc_a, tc_w, tc_sat, rco_a, rco_w, rco_s;

    logic       c_ld_, c_ct_, c_u_;
    logic [3:0] c_d0, c_d1;
    wire  [3:0] cq0, cq1;
    wire        cm0, cm1, ctc0, ctc1, crco0, crco1;
    wire        c_ct1;
    // Models wire delay between stages so stage 1 samples the carry that was
    // present just before cp rose.
    assign #1 c_ct1 = crco0;

    updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_a (
        .cp(cp), .cr_(cr_), .ld_(ld_), .ct_(ct_), .u_(u_), .d(d),
        .q(q_a), .m(m_a), .tc(tc_a), .rco_(rco_a));
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .cp(cp), .cr_(cr_), .ld_(ld_), .ct_(ct_), .u_(u_), .d(d),
        .q(q_w), .m(m_w), .tc(tc_w), .rco_(rco_w));
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .cp(cp), .cr_(cr_), .ld_(ld_), .ct_(ct_), .u_(u_), .d(d),
        .q(q_s), .m(m_s), .tc(tc_sat), .rco_(rco_s));
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) casc0 (
        .cp(cp), .cr_(cr_), .ld_(c_ld_), .ct_(c_ct_), .u_(c_u_), .d(c_d0),
        .q(cq0), .m(cm0), .tc(ctc0), .rco_(crco0));
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) casc1 (
        .cp(cp), .cr_(cr_), .ld_(c_ld_), .ct_(c_ct1), .u_(c_u_), .d(c_d1),
        .q(cq1), .m(cm1), .tc(ctc1), .rco_(crco1));

    int n_chk = 0;
    int n_err = 0;

    // Reference model: index 0 = dut_a, 1 = dut_w, 2 = dut_s.
    int modv[3];
    bit satv[3];
    int mq[3];
    bit mm[3];

    typedef struct {
        logic       ld_n;
        logic       ct_n;
        logic       up;
        logic [3:0] din;
        logic [3:0] q_w;
        logic       m_w;
        logic       tc_w;
        logic [3:0] q_s;
        logic       m_s;
        logic       tc_s;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mm[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (!cr_) begin
                mq[i] = 0;
                mm[i] = 1'b0;
            end else if (!ld_) begin
                mq[i] = (int'(d) > modv[i] - 1) ? modv[i] - 1 : int'(d);
                mm[i] = 1'b0;
            end else if (!ct_) begin
                if (u_) begin
                    mm[i] = (mq[i] == modv[i] - 1);
                    if (!(satv[i] && mm[i])) mq[i] = (mq[i] + 1) % modv[i];
                end else begin
                    mm[i] = (mq[i] == 0);
                    if (!(satv[i] && mm[i])) mq[i] = (mq[i] + modv[i] - 1) % modv[i];
                end
            end
        end
    endtask

    function automatic bit tcm(input int i);
        return (u_ && mq[i] == modv[i] - 1) || (!u_ && mq[i] == 0);
    endfunction

    function automatic bit rcom(input int i);
        return !(tcm(i) && !ct_ && !cp);
    endfunction

    task automatic tick();
        @(posedge cp);
        model_update();
        #1;
    endtask

    task automatic low_phase();
        @(negedge cp);
        #1;
    endtask

    task automatic check_all();
        chk("q_a", q_a, mq[0]);   chk("m_a", m_a, mm[0]);
        chk("tc_a", tc_a, tcm(0)); chk("rco_a", rco_a, rcom(0));
        chk("q_w", q_w, mq[1]);   chk("m_w", m_w, mm[1]);
        chk("tc_w", tc_w, tcm(1)); chk("rco_w", rco_w, rcom(1));
        chk("q_s", q_s, mq[2]);   chk("m_s", m_s, mm[2]);
        chk("tc_s", tc_sat, tcm(2)); chk("rco_s", rco_s, rcom(2));
    endtask

    initial begin
        int cv;
        logic [3:0] exp_q[3];
        logic       exp_m[3];
        logic       tog[3];

        modv[0] = 16; modv[1] = 10; modv[2] = 10;
        satv[0] = 1'b0; satv[1] = 1'b0; satv[2] = 1'b1;
        model_reset();

        tbl[0] = '{1'b0, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd5,  4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 4'd15, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0};

        cr_ = 1'b1; ld_ = 1'b1; ct_ = 1'b1; u_ = 1'b1; d = 4'd0;
        c_ld_ = 1'b1; c_ct_ = 1'b1; c_u_ = 1'b1; c_d0 = 4'd0; c_d1 = 4'd0;

        // ---- Reset ----
        #1 cr_ = 1'b0;
        #1;
        chk("reset_q_a", q_a, 0); chk("reset_m_a", m_a, 0);
        chk("reset_q_w", q_w, 0); chk("reset_q_s", q_s, 0);
        chk("reset_casc", cq1 * 10 + cq0, 0);
        tick();
        chk("reset_hold_q_a", q_a, 0);
        cr_ = 1'b1; ld_ = 1'b0; d = 4'd9;
        tick();
        chk("load9_q_a", q_a, 9);
        ld_ = 1'b1; ct_ = 1'b1;
        #1 cr_ = 1'b0;
        model_reset();
        #1;
        chk("midcycle_clr_q_a", q_a, 0); chk("midcycle_clr_m_a", m_a, 0);
        ld_ = 1'b0; d = 4'd5;
        tick();
        chk("clr_held_q_a", q_a, 0);
        cr_ = 1'b1; ld_ = 1'b1; ct_ = 1'b0; u_ = 1'b1;
        tick();
        chk("first_count_q_a", q_a, 1);

        // ---- Table vectors on the MOD10 wrap and saturate instances ----
        for (int i = 0; i < 10; i++) begin
            ld_ = tbl[i].ld_n; ct_ = tbl[i].ct_n; u_ = tbl[i].up; d = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d_q_w", i), q_w, tbl[i].q_w);
            chk($sformatf("tbl%0d_m_w", i), m_w, tbl[i].m_w);
            chk($sformatf("tbl%0d_tc_w", i), tc_w, tbl[i].tc_w);
            chk($sformatf("tbl%0d_q_s", i), q_s, tbl[i].q_s);
            chk($sformatf("tbl%0d_m_s", i), m_s, tbl[i].m_s);
            chk($sformatf("tbl%0d_tc_s", i), tc_sat, tbl[i].tc_s);
        end

        // ---- Up wrap, MOD10: load 8 then 9, 0, 1 ----
        ld_ = 1'b0; ct_ = 1'b1; u_ = 1'b1; d = 4'd8;
        tick();
        chk("wrap_load_q", q_w, 8);
        ld_ = 1'b1; ct_ = 1'b0;
        tick();
        chk("wrap_e1_q", q_w, 9); chk("wrap_e1_m", m_w, 0); chk("wrap_e1_tc", tc_w, 1);
        chk("wrap_e1_rco_high_phase", rco_w, 1);
        low_phase();
        chk("wrap_e1_rco_low_phase", rco_w, 0);
        tick();
        chk("wrap_e2_q", q_w, 0); chk("wrap_e2_m", m_w, 1); chk("wrap_e2_tc", tc_w, 0);
        low_phase();
        chk("wrap_e2_rco_low_phase", rco_w, 1);
        tick();
        chk("wrap_e3_q", q_w, 1); chk("wrap_e3_m", m_w, 0);

        // ---- Down saturate, MOD10: load 1, then 0,0,0 with m 0,1,1 ----
        ld_ = 1'b0; ct_ = 1'b1; d = 4'd1;
        tick();
        chk("sat_load_q", q_s, 1);
        ld_ = 1'b1; ct_ = 1'b0; u_ = 1'b0;
        exp_q[0] = 4'd0; exp_q[1] = 4'd0; exp_q[2] = 4'd0;
        exp_m[0] = 1'b0; exp_m[1] = 1'b1; exp_m[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_dn%0d_q", i), q_s, exp_q[i]);
            chk($sformatf("sat_dn%0d_m", i), m_s, exp_m[i]);
        end
        // Idle for 5 edges: q and m frozen.
        ct_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d_q", i), q_s, 0);
            chk($sformatf("idle%0d_m", i), m_s, 1);
        end
        ct_ = 1'b0; u_ = 1'b1;
        tick();
        chk("sat_up_q", q_s, 1); chk("sat_up_m", m_s, 0);

        // ---- Direction toggle at MAX with counting disabled ----
        ld_ = 1'b0; ct_ = 1'b1; d = 4'd9;
        tick();
        ld_ = 1'b1;
        tog[0] = 1'b0; tog[1] = 1'b1; tog[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            u_ = tog[i];
            #1;
            chk($sformatf("toggle%0d_tc", i), tc_sat, tog[i]);
            chk($sformatf("toggle%0d_rco", i), rco_s, 1);
        end
        u_ = 1'b1;
        low_phase();
        chk("toggle_rco_low_phase", rco_s, 1);
        chk("toggle_tc_low_phase", tc_sat, 1);
        tick();
        chk("toggle_hold_q", q_s, 9);

        // ---- Cascade of two MOD10 stages ----
        c_ld_ = 1'b0; c_ct_ = 1'b1; c_u_ = 1'b1; c_d1 = 4'd1; c_d0 = 4'd9;
        tick();
        chk("casc_load19", cq1 * 10 + cq0, 19);
        c_ld_ = 1'b1; c_ct_ = 1'b0;
        tick();
        chk("casc_19_to_20", cq1 * 10 + cq0, 20);
        c_ld_ = 1'b0; c_d1 = 4'd9; c_d0 = 4'd9;
        tick();
        chk("casc_load99", cq1 * 10 + cq0, 99);
        c_ld_ = 1'b1;
        tick();
        chk("casc_99_to_00", cq1 * 10 + cq0, 0);
        chk("casc_99_to_00_m1", cm1, 1);
        c_u_ = 1'b0;
        tick();
        chk("casc_00_to_99", cq1 * 10 + cq0, 99);
        chk("casc_00_to_99_m1", cm1, 1);
        cv = 99;
        for (int i = 0; i < 60; i++) begin
            c_u_ = 1'($urandom_range(0, 1));
            c_ct_ = ($urandom_range(0, 3) == 0);
            tick();
            if (!c_ct_) cv = c_u_ ? (cv + 1) % 100 : (cv + 99) % 100;
            chk($sformatf("casc_rand%0d", i), cq1 * 10 + cq0, cv);
        end
        c_ct_ = 1'b1;

        // ---- Randomised run of the three single instances vs model ----
        for (int i = 0; i < 400; i++) begin
            ld_ = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            ct_ = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            u_  = 1'($urandom_range(0, 1));
            d   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                cr_ = 1'b0;
                model_reset();
                #1;
                chk("rand_clr_q_a", q_a, 0); chk("rand_clr_q_w", q_w, 0);
                chk("rand_clr_q_s", q_s, 0); chk("rand_clr_m_s", m_s, 0);
                cr_ = 1'b1;
            end
            low_phase();
            chk("rand_rco_a", rco_a, rcom(0));
            chk("rand_rco_w", rco_w, rcom(1));
            chk("rand_rco_s", rco_s, rcom(2));
            tick();
            check_all();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised synchronous up/down counter with configurable width and modulus.
- Adds a selectable wrap or saturate mode, clamped parallel load, a registered wrap flag and a cascadable active-low ripple-carry output.
- Serves as the general counting primitive for timer, divider and display-scan chains. Several instances cascade via ct_/rco_.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0: 0 = wrap at the bounds; 1 = hold at the bound and flag.

Ports:
- cp, input, 1: clock, rising-edge active.
- cr_, input, 1: asynchronous active-low clear.
- ld_, input, 1: synchronous active-low parallel load.
- ct_, input, 1: active-low count enable; also serves as the cascade input.
- u_, input, 1: direction; 1 = up, 0 = down.
- d, input, WIDTH: parallel load data.
- q, output, WIDTH: count value, registered.
- m, output, 1: registered wrap/saturate flag for the cycle just taken.
- tc, output, 1: combinational terminal count (see Behaviour).
- rco_, output, 1: active-low ripple-carry out, combinational.

Behaviour:
- Reset: cr_ low clears q to 0 and m to 0 asynchronously, with no wait for cp. Both hold while cr_ is low. Release is synchronous to the next cp rise; the first action is on the first rising edge after release.
- Define MAX = MODULUS-1.
- Priority on each rising edge of cp: cr_ > ld_ > ct_.
- Load (ld_=0):
  - q <= d if d <= MAX, else q <= MAX (clamp). Out-of-range values never enter q.
  - m <= 0.
  - Load overrides ct_ and u_.
- Count (ld_=1, ct_=0, u_=1):
  - If q == MAX: q <= 0 when SATURATE=0, or q holds MAX when SATURATE=1. In both cases m <= 1.
  - Else q <= q+1 and m <= 0.
- Count (ld_=1, ct_=0, u_=0):
  - If q == 0: q <= MAX when SATURATE=0, or q holds 0 when SATURATE=1. In both cases m <= 1.
  - Else q <= q-1 and m <= 0.
- Idle (ld_=1, ct_=1): q and m both hold. m keeps its last value until the next counting or load edge.
- m is a registered single-cycle indication per counting edge. It stays high across consecutive saturated edges while ct_ remains low.
- tc = (u_ & q==MAX) | (~u_ & q==0). It is combinational and follows u_ immediately.
- rco_ = ~(tc & ~ct_ & ~cp):
  - Low only during the cp-low half-period when enabled and at the terminal count.
  - Drives ct_ of the next stage so that stage advances on the following cp rise, giving a cascade of N stages that behaves as one wide counter.
  - rco_ is never asserted while ct_=1.
- Direction change mid-count takes effect on the next edge. No extra state and no skipped value.
- Non-power-of-two MODULUS: arithmetic is WIDTH bits wide, and values above MAX are unreachable by counting.
- cr_ asserted mid-operation (between edges or coincident with a cp rise) wins. q=0 and m=0 immediately.
- Edge cases that must hold:
  - Load of d==MAX with u_=1 followed by one count edge wraps to 0.
  - ld_ and ct_ both low gives load only.

Test Plan:
- Reset: WIDTH=4, MODULUS=16; q=9, assert cr_ between edges -> q=0 and m=0 immediately, held until release; first count edge after release gives q=1.
- Up wrap: WIDTH=4, MODULUS=10, SATURATE=0; load 8, count up 3 edges:
  - q goes 9, 0, 1.
  - m=1 only after the 9->0 edge.
  - tc=1 while q=9, u_=1.
  - rco_ low only in the cp-low phase at q=9.
- Down saturate: MODULUS=10, SATURATE=1; load 1, count down 3 edges -> q goes 0, 0, 0 and m is 0, 1, 1. Then u_=1 -> q=1 and m=0.
- Load clamp and priority:
  - MODULUS=10, d=13, ld_=0, ct_=0 -> q=9 and m=0 (no count on that edge).
  - d=5 -> q=5.
- Cascade: two WIDTH=4, MODULUS=10 stages, rco_ of stage 0 to ct_ of stage 1; start at 19 and count up:
  - 19 -> 20.
  - 99 -> 00, with the stage-1 m pulse.
  - Down from 00 -> 99.
- Idle/direction: ct_=1 for 5 edges -> q and m frozen. Toggle u_ at q=MAX with ct_=1 -> tc follows combinationally and rco_ stays 1.
